wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Sits directly upstream of the register file's single write port.
//  Merges the CPU writeback stream with register writes requested by game I/O logic
//  (controller input, timers). External requests are buffered in a small FIFO.
//  They are drained only in cycles where the CPU is not writing.
//  Drives the register file's ctrl_writeEnable / ctrl_writeReg / data_writeReg inputs.
// PARAMETERS
//  DEPTH         4   external request FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   cycles a pending ext head may wait before cpu_stall (guard build only)
// PORTS
//  clock             in   1   single clock; all state updates on posedge
//  ctrl_reset        in   1   synchronous, active-high reset
//  cpu_we            in   1   CPU writeback valid
//  cpu_rd            in   5   CPU destination register
//  cpu_data          in   32  CPU writeback data
//  ext_valid         in   1   external write request valid
//  ext_ready         out  1   FIFO can accept; transfer when ext_valid & ext_ready at posedge
//  ext_rd            in   5   external destination register
//  ext_data          in   32  external write data
//  ctrl_writeEnable  out  1   to register file write enable
//  ctrl_writeReg     out  5   to register file write address
//  data_writeReg     out  32  to register file write data
//  ext_level         out  $clog2(DEPTH)+1  current FIFO occupancy
//  cpu_stall         out  1   CPU must hold its writeback (guard build only, else 0)
// BEHAVIOUR
//  - Reset: FIFO emptied, ext_level=0, wait counter=0.
//  - While ctrl_reset=1: ext_ready=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, cpu_stall=0.
//  - Output mux is combinational from current inputs/state.
//  - CPU path has 0-cycle latency; the register file commits it on the same cycle's negedge.
//  - Grant: cpu_we=1 -> outputs = {1, cpu_rd, cpu_data}.
//    Else if FIFO non-empty -> outputs = {1, head.rd, head.data}; head popped at posedge.
//    Else all outputs 0.
//  - Ext path minimum latency 1 cycle: an accepted request is presented no earlier than the next cycle.
//    There is no empty-FIFO bypass.
//  - ext_ready = ~full.
//  - A push while full is not accepted, even if a pop happens in the same cycle.
//  - A push and a pop in the same cycle: both occur; occupancy is unchanged.
//  - Ext request with ext_rd=0 is accepted (handshake completes) and discarded.
//    It is never enqueued and never presented. CPU rd=0 passes through unchanged.
//  - Ordering: ext writes are presented in acceptance order.
//  - Same-register conflicts resolve as last presentation wins; no merging or cancellation.
//  - Pointers wrap modulo DEPTH.
//  - A full FIFO under continuous cpu_we holds indefinitely with ext_ready=0 (non-guard build).
// CONFIGURATION
//  Macro WB_STARVE_GUARD_EN.
//  Defined:
//  - Wait counter increments each cycle the FIFO is non-empty and the head is not granted.
//  - Counter clears on a head pop and on reset.
//  - When counter >= STARVE_LIMIT: cpu_stall=1 and the head is granted regardless of cpu_we.
//  - CPU must hold cpu_we/cpu_rd/cpu_data stable until cpu_stall falls.
//  - cpu_stall falls the cycle after the pop.
//  Undefined:
//  - cpu_stall tied 0, no counter; the CPU always has priority.
// STRUCTURE
//  - wb_pkg: REG_W=32, ADDR_W=5, typedef struct {addr[4:0], data[31:0]} wb_req_t.
//  - Sub-module wb_req_fifo: synchronous DEPTH-entry FIFO of wb_req_t.
//    Ports push/pop/full/empty/level/head; head visible combinationally.
//  - Arbiter, zero filter and starvation counter live in wb_port_arbiter.
// TESTING
//  1. ext push rd=5 data=0xA5A5_0001, cpu_we=0 -> next cycle outputs {1,5,0xA5A5_0001}; level 1->0.
//  2. cpu_we=1 rd=7 same cycle as FIFO head rd=3 -> outputs rd=7.
//     Head presented first cycle cpu_we=0; level unchanged until then.
//  3. Push DEPTH=4 requests with cpu_we held 1 -> ext_ready=0 after 4th; 5th not accepted.
//     Simultaneous push+pop at level 2 keeps level 2.
//  4. ext push rd=0 -> ext_ready handshake completes; level stays 0; ctrl_writeEnable never asserts.
//  5. ctrl_reset pulse with level=3 -> next cycle level=0, ext_ready=1, no stale write presented.
//  6. (guard) head pending, cpu_we=1 for 8 cycles -> cpu_stall=1, head written.
//     cpu_stall=0 next cycle; CPU write then presented.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared widths and the request record used by the register-file write-port
// arbiter and its request FIFO.
//   REG_W    : register data width
//   ADDR_W   : register address width
//   wb_req_t : one pending register write {addr, data}
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int REQ_W  = ADDR_W + REG_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// ---------------------------------------------------------------------------
// wb_req_fifo
// Synchronous DEPTH-entry FIFO of wb_req_t. The head entry is visible
// combinationally so the arbiter can present it in the same cycle it pops.
// A push while full is dropped even when a pop happens in the same cycle.
// Ports:
//   clock, ctrl_reset : clock and synchronous active-high reset
//   push, push_req    : write request and the record to store
//   pop               : remove the head entry (ignored while empty)
//   full, empty       : occupancy flags
//   level             : current occupancy, 0..DEPTH
//   head              : record at the read pointer
// ---------------------------------------------------------------------------
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   push,
    input  logic [REQ_W-1:0]       push_req,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [REQ_W-1:0]       head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once the level says
    // they were written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wb_req_t'(push_req);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Sits in front of the register file's single write port and merges the CPU
// writeback stream with writes requested by game I/O logic. External
// requests are buffered in wb_req_fifo and drained in cycles where the CPU
// is not writing. Requests addressed to r0 are accepted and discarded.
// Optional build macro WB_STARVE_GUARD_EN: a head entry that has waited
// STARVE_LIMIT cycles is forced through and the CPU is stalled for that
// cycle via cpu_stall. Without the macro cpu_stall is tied low.
// Ports:
//   clock, ctrl_reset          : clock, synchronous active-high reset
//   cpu_we/cpu_rd/cpu_data     : CPU writeback (zero-latency path)
//   ext_valid/ext_ready        : external request handshake
//   ext_rd/ext_data            : external request payload
//   ctrl_writeEnable,
//   ctrl_writeReg,
//   data_writeReg              : register file write port
//   ext_level                  : FIFO occupancy
//   cpu_stall                  : CPU must hold its writeback
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   cpu_we,
    input  logic [4:0]             cpu_rd,
    input  logic [31:0]            cpu_data,
    input  logic                   ext_valid,
    output logic                   ext_ready,
    input  logic [4:0]             ext_rd,
    input  logic [31:0]            ext_data,
    output logic                   ctrl_writeEnable,
    output logic [4:0]             ctrl_writeReg,
    output logic [31:0]            data_writeReg,
    output logic [$clog2(DEPTH):0] ext_level,
    output logic                   cpu_stall
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("wb_port_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             grant_head;
    logic [REQ_W-1:0] head_bits;
    wb_req_t          head;
    wb_req_t          push_req;

    assign head     = wb_req_t'(head_bits);
    assign push_req = '{addr: ext_rd, data: ext_data};

    // Writes to r0 complete the handshake but never occupy a FIFO slot.
    assign ext_ready = ~ctrl_reset & ~fifo_full;
    assign fifo_push = ext_valid & ext_ready & (ext_rd != '0);

    wb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (fifo_push),
        .push_req   (push_req),
        .pop        (grant_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (ext_level),
        .head       (head_bits)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             starve;

    assign starve     = ~fifo_empty & (wait_cnt >= CNT_W'(STARVE_LIMIT));
    assign grant_head = ~ctrl_reset & ~fifo_empty & (~cpu_we | starve);
    assign cpu_stall  = ~ctrl_reset & starve;

    // Counts cycles the head waits behind the CPU; once it reaches the limit
    // the head is granted, which clears it, so it never runs past the limit.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wait_cnt <= '0;
        end else if (grant_head) begin
            wait_cnt <= '0;
        end else if (~fifo_empty && wait_cnt < CNT_W'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign grant_head = ~ctrl_reset & ~fifo_empty & ~cpu_we;
    assign cpu_stall  = 1'b0;
`endif

    // Write-port mux: the FIFO head wins only when granted (CPU idle, or a
    // starved head in the guard build); otherwise the CPU passes straight
    // through, r0 included.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (grant_head) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = head.addr;
            data_writeReg    = head.data;
        end else if (cpu_we && !ctrl_reset) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = cpu_rd;
            data_writeReg    = cpu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Scoreboard bench for wb_port_arbiter. The driver keeps a queue-based model
// of pending external writes, predicts every register-file write and pushes
// it into an expectation queue; a separate monitor pops and compares each
// time the DUT asserts ctrl_writeEnable. Handshake, level and stall are
// compared against the model each cycle. Honours WB_STARVE_GUARD_EN.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clock;
    logic        ctrl_reset;
    logic        cpu_we;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_data;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_rd;
    logic [31:0] ext_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [2:0]  ext_level;
    logic        cpu_stall;

    int total;
    int bad;

    logic [36:0] model_fifo[$];
    logic [36:0] exp_q[$];
    int          model_wait;
    bit          hold;
    logic        hold_we;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .cpu_we           (cpu_we),
        .cpu_rd           (cpu_rd),
        .cpu_data         (cpu_data),
        .ext_valid        (ext_valid),
        .ext_ready        (ext_ready),
        .ext_rd           (ext_rd),
        .ext_data         (ext_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ext_level        (ext_level),
        .cpu_stall        (cpu_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // One cycle: drive inputs, advance the model, then check the handshake
    // side at negedge. Called right after a posedge.
    task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] d,
                                 input logic ev, input logic [4:0] erd, input logic [31:0] ed);
        logic        c_we;
        logic [4:0]  c_rd;
        logic [31:0] c_d;
        int          lvl;
        bit          rdy;
        bit          stall;
        bit          grant;
        c_we = we;
        c_rd = rd;
        c_d  = d;
        if (hold) begin
            c_we = hold_we;
            c_rd = hold_rd;
            c_d  = hold_data;
        end
        cpu_we    = c_we;
        cpu_rd    = c_rd;
        cpu_data  = c_d;
        ext_valid = ev;
        ext_rd    = erd;
        ext_data  = ed;

        lvl   = model_fifo.size();
        rdy   = (lvl < DEPTH);
        stall = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        stall = (lvl > 0) && (model_wait >= STARVE_LIMIT);
`endif
        grant = (lvl > 0) && (!c_we || stall);
        if (grant) exp_q.push_back(model_fifo.pop_front());
        else if (c_we) exp_q.push_back({c_rd, c_d});
        if (ev && rdy && erd != 5'd0) model_fifo.push_back({erd, ed});
        if (grant) model_wait = 0;
        else if (lvl > 0) model_wait++;
        hold      = stall;
        hold_we   = c_we;
        hold_rd   = c_rd;
        hold_data = c_d;

        @(negedge clock);
        checkOutput("ext_ready", 64'(ext_ready), 64'(rdy));
        checkOutput("ext_level", 64'(ext_level), 64'(lvl));
        checkOutput("cpu_stall", 64'(cpu_stall), 64'(stall));
        @(posedge clock);
        #1;
    endtask

    // Reset cycle with busy inputs: everything must stay quiet.
    task automatic doReset();
        ctrl_reset = 1'b1;
        cpu_we     = 1'b1;
        cpu_rd     = 5'd9;
        cpu_data   = 32'hDEAD_BEEF;
        ext_valid  = 1'b1;
        ext_rd     = 5'd4;
        ext_data   = 32'h1234_5678;
        @(negedge clock);
        checkOutput("rst_ext_ready", 64'(ext_ready), 64'd0);
        checkOutput("rst_write_en", 64'(ctrl_writeEnable), 64'd0);
        checkOutput("rst_write_reg", 64'(ctrl_writeReg), 64'd0);
        checkOutput("rst_write_data", 64'(data_writeReg), 64'd0);
        checkOutput("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        model_fifo.delete();
        model_wait = 0;
        hold       = 1'b0;
    endtask

    // Monitor: every presented write must match the oldest prediction.
    always @(negedge clock) begin
        if (!ctrl_reset && ctrl_writeEnable) begin
            if (exp_q.size() == 0) begin
                bad++;
                total++;
                $display("[TB] FAIL spurious_write actual=0x%0h required=none",
                         {ctrl_writeReg, data_writeReg});
            end else begin
                checkOutput("write", 64'({ctrl_writeReg, data_writeReg}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        hold       = 1'b0;
        model_wait = 0;
        ctrl_reset = 1'b1;
        cpu_we     = 1'b0;
        cpu_rd     = '0;
        cpu_data   = '0;
        ext_valid  = 1'b0;
        ext_rd     = '0;
        ext_data   = '0;
        doReset();

        // Single external write, presented the cycle after acceptance.
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hA5A5_0001);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // CPU priority over a waiting head.
        applyStimulus(0, 0, 0, 1, 5'd3, 32'h0000_0333);
        applyStimulus(1, 5'd7, 32'h0000_0777, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Fill under CPU writes; fifth push refused.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5'd1, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        // Push and pop together at level 2.
        applyStimulus(0, 0, 0, 1, 5'd20, 32'h0000_2020);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // r0 external write discarded; CPU r0 passes.
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF_0000);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd0, 32'h0000_00AA, 0, 0, 0);

        // Reset with three pending entries leaves nothing behind.
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'd2, 32'(i), 1, 5'(i + 1), 32'(i));
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Long CPU burst behind a pending head (starvation in guard build).
        applyStimulus(1, 5'd8, 32'h0000_0808, 1, 5'd12, 32'h0000_0C0C);
        for (int i = 0; i < 10; i++) applyStimulus(1, 5'd8, 32'h0000_0900 + 32'(i), 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomized traffic with varying CPU load.
        for (int i = 0; i < 3000; i++) begin
            int          load;
            logic        we;
            logic [4:0]  erd;
            load = (i / 200) % 3;
            we   = (load == 0) ? ($urandom_range(0, 3) != 0) :
                   (load == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            erd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (i % 1000 == 999) doReset();
            applyStimulus(we, 5'($urandom_range(0, 31)), $urandom(),
                          ($urandom_range(0, 9) < 6), erd, $urandom());
        end

        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
